// File: rtl/tb_mem_ctrl_pkg.sv
// tb_mem_ctrl_pkg: shared FSM states, bank/lane types and the bank-role helpers.
package tb_mem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    localparam int NBANK = 4;

    typedef logic [1:0] bank_t;
    typedef logic       lane_t;

    function automatic bank_t train_bank(bank_t b);
        return b - bank_t'(1);
    endfunction

    function automatic bank_t dec_bank(bank_t b);
        return b - bank_t'(3);
    endfunction

endpackage

// File: rtl/tb_mem_ctrl_if.sv
// tb_mem_ctrl_if: bus between ACS/survivor RAM/traceback lanes and the controller; TB_FLUSH_EN adds flush/pad/flush_done.
interface tb_mem_ctrl_if import tb_mem_ctrl_pkg::*; #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic                   acs_valid;
    logic                   clear;
    logic [NBANK-1:0]       mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [1:0][1:0]        rd_bank;
    logic [1:0][AW-1:0]     rd_addr;
    logic [1:0]             tb_en;
    logic [1:0]             tb_sel;
    logic                   out_lane;
    logic [AW-1:0]          out_addr;
    logic                   busy;
    logic                   err;
`ifdef TB_FLUSH_EN
    logic                   flush;
    logic                   pad;
    logic                   flush_done;
`endif

    modport master (
`ifdef TB_FLUSH_EN
        output flush,
        input  pad, flush_done,
`endif
        output acs_valid, clear,
        input  mem_we, mem_waddr, rd_bank, rd_addr, tb_en, tb_sel,
        input  out_lane, out_addr, busy, err
    );

    modport slave (
`ifdef TB_FLUSH_EN
        input  flush,
        output pad, flush_done,
`endif
        input  acs_valid, clear,
        output mem_we, mem_waddr, rd_bank, rd_addr, tb_en, tb_sel,
        output out_lane, out_addr, busy, err
    );

endinterface

// File: rtl/tb_mem_ctrl_align_pipe.sv
// tb_align_pipe: N-stage, W-bit delay line lining control up with RAM/tbu register latency.
module tb_align_pipe #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [N*W-1:0] r_sr;

    if (N == 1) begin : g_one
        // single register stage
        always_ff @(posedge clk) begin
            if (rst) r_sr <= '0;
            else     r_sr <= i_d;
        end
    end else begin : g_many
        // newest sample enters at the bottom, oldest leaves at the top
        always_ff @(posedge clk) begin
            if (rst) r_sr <= '0;
            else     r_sr <= {r_sr[(N-1)*W-1:0], i_d};
        end
    end

    assign o_q = r_sr[N*W-1 -: W];

endmodule

// File: rtl/tb_mem_ctrl.sv
// tb_mem_ctrl: survivor-RAM write sequencing and two-lane traceback scheduling; optional TB_FLUSH_EN zero-pad flush.
module tb_mem_ctrl import tb_mem_ctrl_pkg::*; #(
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    tb_mem_ctrl_if.slave bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        r_state, w_state_nx;
    logic [AW-1:0] r_wcnt, w_raddr;
    bank_t         r_bank;
    logic [1:0]    r_f;
    logic          w_go, w_wr, w_wrap, w_trn, w_dec, w_fl_end;
    lane_t         w_dec_lane;
    logic [1:0]    w_en, w_sel;
    logic [3:0]    w_tb_q;
    logic [AW:0]   w_out_d, w_out_q;

`ifdef TB_FLUSH_EN
    logic       r_pad, r_flush_done;
    logic [1:0] r_fl_cnt;

    assign w_go            = r_state == RUN && (bus.acs_valid || bus.flush || r_pad);
    assign w_fl_end        = r_pad && w_wrap && r_fl_cnt == 2'd0;
    assign bus.pad         = r_pad;
    assign bus.flush_done  = r_flush_done;

    // pad until the open frame and two more are written so every real frame gets decoded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pad        <= 1'b0;
            r_fl_cnt     <= 2'd0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= w_fl_end;
            if (w_fl_end)
                r_pad <= 1'b0;
            else if (r_state == RUN && bus.flush && !r_pad) begin
                r_pad    <= 1'b1;
                r_fl_cnt <= w_wrap ? 2'd1 : 2'd2;
            end else if (r_pad && w_wrap)
                r_fl_cnt <= r_fl_cnt - 2'd1;
        end
    end
`else
    assign w_go     = r_state == RUN && bus.acs_valid;
    assign w_fl_end = 1'b0;
`endif

    assign w_wr           = w_go || (r_state == IDLE && bus.acs_valid);
    assign w_wrap         = w_wr && r_wcnt == LAST;
    assign w_raddr        = LAST - r_wcnt;
    assign w_trn          = w_go && r_f >= 2'd2;
    assign w_dec          = w_go && r_f == 2'd3;
    assign w_dec_lane     = ~r_bank[0];
    assign bus.mem_we     = w_wr ? NBANK'(1) << r_bank : '0;
    assign bus.mem_waddr  = r_wcnt;
    assign bus.busy       = r_state == RUN;
    assign bus.err        = r_state == ERR;

    // next state: start on first vector, any gap in RUN is an error, clear or flush end returns to IDLE
    always_comb begin
        w_state_nx = r_state;
        if (r_state == IDLE && bus.acs_valid) w_state_nx = RUN;
        if (r_state == RUN && !w_go)          w_state_nx = ERR;
        if ((r_state == ERR && bus.clear) || w_fl_end) w_state_nx = IDLE;
    end

    // lane roles: lane b%2 trains on bank b-1, the other lane decodes bank b-3
    always_comb begin
        w_en        = '0;
        w_sel       = '0;
        bus.rd_bank = '0;
        bus.rd_addr = '0;
        for (int l = 0; l < 2; l++) begin
            w_sel[l]       = w_dec && w_dec_lane == lane_t'(l);
            w_en[l]        = w_sel[l] || (w_trn && r_bank[0] == lane_t'(l));
            bus.rd_bank[l] = w_sel[l] ? dec_bank(r_bank) : w_en[l] ? train_bank(r_bank) : '0;
            bus.rd_addr[l] = w_en[l] ? w_raddr : '0;
        end
    end

    // state register plus write counter, wrapping bank index and saturating startup frame count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_bank  <= '0;
            r_f     <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_state_nx == IDLE) begin
                r_wcnt <= '0;
                r_bank <= '0;
                r_f    <= '0;
            end else if (w_wr) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (w_wrap) begin
                    r_bank <= r_bank + 1'b1;
                    r_f    <= r_f == 2'd3 ? r_f : r_f + 2'd1;
                end
            end
        end
    end

    assign w_out_d = w_dec ? {w_dec_lane, w_raddr} : '0;

    tb_align_pipe #(.W(4), .N(1)) u_tb_pipe (
        .clk (clk),
        .rst (rst),
        .i_d ({w_sel, w_en}),
        .o_q (w_tb_q)
    );

    tb_align_pipe #(.W(AW + 1), .N(2)) u_out_pipe (
        .clk (clk),
        .rst (rst),
        .i_d (w_out_d),
        .o_q (w_out_q)
    );

    assign bus.tb_sel   = w_tb_q[3:2];
    assign bus.tb_en    = w_tb_q[1:0];
    assign bus.out_lane = w_out_q[AW];
    assign bus.out_addr = w_out_q[AW-1:0];

endmodule
